// File: rtl/fmul32_pkg.sv
// Shared constants and types for the FMUL32 round/pack output stage.
package fmul32_pkg;
    localparam logic [7:0]  EXP_MAX = 8'hFF;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam int          FRAC_HI = 46;
    localparam int          FRAC_LO = 24;
    localparam int          GUARD   = 23;

    typedef struct packed {
        logic ovf;
        logic inx;
        logic unf;
    } flags_t;
endpackage

// File: rtl/fmul32_round_pack_if.sv
// Upstream beat and downstream result bus of the round/pack stage.
interface fmul32_round_pack_if #(parameter int DATA_W = 32, parameter int MANT_W = 48);
    logic              in_valid;
    logic              in_ready;
    logic              sign_in;
    logic [7:0]        exp_in;
    logic [MANT_W-1:0] mant_in;
    logic              nan_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] res_out;
    logic              flag_ovf;
    logic              flag_inx;
    logic              flag_unf;

    modport slave (
        input  in_valid, sign_in, exp_in, mant_in, nan_in, out_ready,
        output in_ready, out_valid, res_out, flag_ovf, flag_inx, flag_unf
    );
    modport master (
        output in_valid, sign_in, exp_in, mant_in, nan_in, out_ready,
        input  in_ready, out_valid, res_out, flag_ovf, flag_inx, flag_unf
    );
endinterface

// File: rtl/fmul32_rne_round.sv
// Round-to-nearest-even of the mantissa product and IEEE single packing (NaN excluded).
module fmul32_rne_round
    import fmul32_pkg::*;
#(
    parameter int MANT_W = 48
) (
    input  logic [MANT_W-1:0] mant_i,
    input  logic [7:0]        exp_i,
    input  logic              sign_i,
    output logic [31:0]       res_o,
    output flags_t            flags_o
);
    logic        g, s, l, rup;
    logic [30:0] ef;
    logic        unused_hidden;

    // Hidden bit is implied by the exponent field, so it never enters the word.
    assign unused_hidden = mant_i[MANT_W-1];

    always_comb begin
        g       = mant_i[GUARD];
        s       = |mant_i[GUARD-1:0];
        l       = mant_i[FRAC_LO];
        rup     = g & (s | l);
        // Fraction carry ripples into the exponent, covering denormal->normal and overflow.
        ef      = {exp_i, mant_i[FRAC_HI:FRAC_LO]} + 31'(rup);
        res_o   = {sign_i, ef};
        flags_o = '0;
        if (exp_i == EXP_MAX) begin
            res_o       = {sign_i, EXP_MAX, 23'h0};
            flags_o.ovf = 1'b1;
        end else begin
            flags_o.inx = g | s;
            if (ef[30:23] == EXP_MAX) begin
                flags_o.ovf = 1'b1;
                flags_o.inx = 1'b1;
            end
            flags_o.unf = (exp_i == 8'h00) & flags_o.inx;
        end
    end
endmodule

// File: rtl/fmul32_round_pack.sv
// FMUL32 output stage: round/pack, then two valid/ready register stages.
module fmul32_round_pack
    import fmul32_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int MANT_W = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    fmul32_round_pack_if.slave bus
);
    logic [31:0]       rnd_res;
    flags_t            rnd_flags;

    logic              s1_vld_q, s1_vld_d, s1_nan_q, s1_nan_d;
    logic [31:0]       s1_res_q, s1_res_d;
    flags_t            s1_flags_q, s1_flags_d;
    logic              s2_vld_q, s2_vld_d;
    logic [DATA_W-1:0] s2_res_q, s2_res_d;
    flags_t            s2_flags_q, s2_flags_d;
    logic              s2_rdy, s1_load, s2_load;

    fmul32_rne_round #(.MANT_W(MANT_W)) u_rnd (
        .mant_i  (bus.mant_in),
        .exp_i   (bus.exp_in),
        .sign_i  (bus.sign_in),
        .res_o   (rnd_res),
        .flags_o (rnd_flags)
    );

    assign s2_rdy       = !s2_vld_q | bus.out_ready;
    assign bus.in_ready = rst_n & (!s1_vld_q | s2_rdy);
    assign s1_load      = bus.in_valid & bus.in_ready;
    assign s2_load      = s1_vld_q & s2_rdy;

    always_comb begin
        s1_vld_d   = s1_load | (s1_vld_q & !s2_load);
        s1_res_d   = s1_res_q;
        s1_flags_d = s1_flags_q;
        s1_nan_d   = s1_nan_q;
        s2_vld_d   = s2_load | (s2_vld_q & !bus.out_ready);
        s2_res_d   = s2_res_q;
        s2_flags_d = s2_flags_q;
        if (s1_load) begin
            s1_res_d   = rnd_res;
            s1_flags_d = rnd_flags;
            s1_nan_d   = bus.nan_in;
        end
        // NaN selection is resolved on the way into the output register.
        if (s2_load) begin
            s2_res_d   = s1_nan_q ? DATA_W'(QNAN) : DATA_W'(s1_res_q);
            s2_flags_d = s1_nan_q ? '0 : s1_flags_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q   <= 1'b0;
            s1_res_q   <= '0;
            s1_flags_q <= '0;
            s1_nan_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
            s2_res_q   <= '0;
            s2_flags_q <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_res_q   <= s1_res_d;
            s1_flags_q <= s1_flags_d;
            s1_nan_q   <= s1_nan_d;
            s2_vld_q   <= s2_vld_d;
            s2_res_q   <= s2_res_d;
            s2_flags_q <= s2_flags_d;
        end
    end

    assign bus.out_valid = s2_vld_q;
    assign bus.res_out   = s2_res_q;
    assign bus.flag_ovf  = s2_flags_q.ovf;
    assign bus.flag_inx  = s2_flags_q.inx;
    assign bus.flag_unf  = s2_flags_q.unf;
endmodule

// File: tb/tb_fmul32_round_pack.sv
// Scoreboard bench for fmul32_round_pack: directed rounding cases, back-pressure, reset, random stream.
module tb_fmul32_round_pack;
    typedef struct packed {
        logic [31:0] res;
        logic [2:0]  flg;   // {ovf, inx, unf}
    } exp_t;

    logic clk, rst_n;
    int   n_chk = 0, n_fail = 0;
    exp_t sb[$];
    exp_t drv_exp;
    logic rand_rdy = 1'b0;

    fmul32_round_pack_if #(.DATA_W(32), .MANT_W(48)) bus ();

    fmul32_round_pack #(.DATA_W(32), .MANT_W(48)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Reference: compare the discarded 24 bits against one half.
    function automatic exp_t model(input logic s, input logic [7:0] e, input logic [47:0] m, input logic n);
        exp_t        r;
        logic [22:0] f;
        logic [23:0] rem;
        logic        up;
        logic [31:0] w;
        f   = m[46:24];
        rem = m[23:0];
        up  = (rem > 24'h800000) || ((rem == 24'h800000) && f[0]);
        w   = {1'b0, e, f} + {31'd0, up};
        if (n) begin
            r.res = 32'h7FC00000;
            r.flg = 3'b000;
        end else if (e == 8'hFF) begin
            r.res = {s, 8'hFF, 23'h0};
            r.flg = 3'b100;
        end else begin
            r.res    = {s, w[30:0]};
            r.flg[1] = (rem != 24'd0);
            r.flg[2] = (w[30:23] == 8'hFF);
            if (r.flg[2]) r.flg[1] = 1'b1;
            r.flg[0] = (e == 8'h00) && r.flg[1];
        end
        return r;
    endfunction

    // Output side: every cycle with out_valid must match the head, so stalls also check stability.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", {31'd0, bus.out_valid}, 32'd0);
                end else begin
                    chk("res", bus.res_out, sb[0].res);
                    chk("flags", {29'd0, bus.flag_ovf, bus.flag_inx, bus.flag_unf}, {29'd0, sb[0].flg});
                    if (bus.out_ready) void'(sb.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready) sb.push_back(drv_exp);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic s, input logic [7:0] e, input logic [47:0] m, input logic n, input exp_t x);
        int t = 0;
        bus.sign_in  = s;
        bus.exp_in   = e;
        bus.mant_in  = m;
        bus.nan_in   = n;
        drv_exp      = x;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        chk("send_accept", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic        s, n;
        logic [7:0]  e;
        logic [47:0] m;
        s = 1'($urandom_range(0, 1));
        n = ($urandom_range(0, 15) == 0);
        case ($urandom_range(0, 5))
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       e = 8'hFE;
            default: e = 8'($urandom);
        endcase
        m = {16'($urandom), 32'($urandom)};
        if ($urandom_range(0, 3) == 0) m[23:0] = 24'h800000;
        if ($urandom_range(0, 3) == 0) m[46:24] = 23'h7FFFFF;
        if (e != 8'h00) m[47] = 1'b1;
        send(s, e, m, n, model(s, e, m, n));
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            t++;
            @(negedge clk);
        end
        chk("drain", sb.size(), 32'd0);
    endtask

    initial begin
        logic saw_stall;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.sign_in   = 1'b0;
        bus.exp_in    = 8'h00;
        bus.mant_in   = 48'h0;
        bus.nan_in    = 1'b0;
        bus.out_ready = 1'b1;
        drv_exp       = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_res", bus.res_out, 32'd0);
        chk("rst_flags", {29'd0, bus.flag_ovf, bus.flag_inx, bus.flag_unf}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Exact 1.0 with latency check.
        send(1'b0, 8'h7F, 48'h800000_000000, 1'b0, '{32'h3F800000, 3'b000});
        @(negedge clk);
        chk("lat_n1", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_n2", {31'd0, bus.out_valid}, 32'd1);
        @(posedge clk);
        #1;

        // Directed rounding and special cases, streamed back to back.
        send(1'b0, 8'h7F, 48'h800000_800000, 1'b0, '{32'h3F800000, 3'b010});
        send(1'b0, 8'h7F, 48'h800001_800000, 1'b0, '{32'h3F800002, 3'b010});
        send(1'b0, 8'hFE, 48'hFFFFFF_800000, 1'b0, '{32'h7F800000, 3'b110});
        send(1'b0, 8'h00, 48'h7FFFFF_C00000, 1'b0, '{32'h00800000, 3'b011});
        send(1'b1, 8'h12, 48'h123456_789ABC, 1'b1, '{32'h7FC00000, 3'b000});
        send(1'b1, 8'hFF, 48'hFFFFFF_FFFFFF, 1'b0, '{32'hFF800000, 3'b100});
        wait_drain();

        // Back-pressure: four beats while out_ready is held low for several cycles.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        saw_stall = 1'b0;
        fork
            repeat (4) send_rand();
            begin
                repeat (5) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
            repeat (6) begin
                @(negedge clk);
                if (bus.in_valid && !bus.in_ready) saw_stall = 1'b1;
            end
        join
        chk("bp_stall_seen", {31'd0, saw_stall}, 32'd1);
        wait_drain();

        // Reset while both stages hold data.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send_rand();
        send_rand();
        @(negedge clk);
        chk("full_before_rst", {31'd0, bus.out_valid}, 32'd1);
        chk("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_res", bus.res_out, 32'd0);
        chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        send(1'b0, 8'h80, 48'hC00000_000001, 1'b0, '{32'h40400000, 3'b010});
        @(negedge clk);
        chk("postrst_lat_n1", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        chk("postrst_lat_n2", {31'd0, bus.out_valid}, 32'd1);
        wait_drain();

        // Random stream with random back-pressure.
        @(posedge clk);
        #2;
        rand_rdy = 1'b1;
        repeat (60) send_rand();
        #2;
        rand_rdy      = 1'b0;
        bus.out_ready = 1'b1;
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
